// File: rtl/tour_pkg.sv
// Shared constants, state encoding and command builder for the knight-tour
// move sequencer.
package tour_pkg;

  localparam int NUM_MOVES_DEF = 24;

  localparam logic [3:0] OP_MOVE     = 4'h4;
  localparam logic [3:0] OP_MOVE_FAN = 4'h5;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    VERT  = 3'd1,
    VWAIT = 3'd2,
    HORZ  = 3'd3,
    HWAIT = 3'd4
  } tour_state_e;

  function automatic logic [15:0] leg_cmd(input logic [3:0] op,
                                          input logic [7:0] heading,
                                          input logic [1:0] squares);
    return {op, heading, 2'b00, squares};
  endfunction

endpackage

// File: rtl/knight_move_decode.sv
// Turns a one-hot knight move into its vertical and horizontal cmd_proc legs.
// Anything that is not exactly one-hot decodes as bit 0.
module knight_move_decode
  import tour_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd
);

  logic       up_s;
  logic       right_s;
  logic [1:0] dy_mag_s;
  logic [1:0] dx_mag_s;

  // Direction and magnitude of each leg for the eight knight moves
  always_comb begin
    up_s     = 1'b1;
    right_s  = 1'b0;
    dy_mag_s = 2'd2;
    dx_mag_s = 2'd1;
    case (move)
      8'h01: begin up_s = 1'b1; right_s = 1'b0; dy_mag_s = 2'd2; dx_mag_s = 2'd1; end
      8'h02: begin up_s = 1'b1; right_s = 1'b1; dy_mag_s = 2'd2; dx_mag_s = 2'd1; end
      8'h04: begin up_s = 1'b1; right_s = 1'b0; dy_mag_s = 2'd1; dx_mag_s = 2'd2; end
      8'h08: begin up_s = 1'b0; right_s = 1'b0; dy_mag_s = 2'd1; dx_mag_s = 2'd2; end
      8'h10: begin up_s = 1'b0; right_s = 1'b0; dy_mag_s = 2'd2; dx_mag_s = 2'd1; end
      8'h20: begin up_s = 1'b0; right_s = 1'b1; dy_mag_s = 2'd2; dx_mag_s = 2'd1; end
      8'h40: begin up_s = 1'b0; right_s = 1'b1; dy_mag_s = 2'd1; dx_mag_s = 2'd2; end
      8'h80: begin up_s = 1'b1; right_s = 1'b1; dy_mag_s = 2'd1; dx_mag_s = 2'd2; end
      default: begin up_s = 1'b1; right_s = 1'b0; dy_mag_s = 2'd2; dx_mag_s = 2'd1; end
    endcase
  end

  assign vert_cmd = leg_cmd(OP_MOVE,     up_s    ? HDG_N : HDG_S, dy_mag_s);
  assign horz_cmd = leg_cmd(OP_MOVE_FAN, right_s ? HDG_E : HDG_W, dx_mag_s);

endmodule

// File: rtl/tour_move_sequencer.sv
// Muxes UART commands to cmd_proc while idle, and replays a solved knight tour
// as vertical/horizontal command pairs when start_tour fires.
module tour_move_sequencer
  import tour_pkg::*;
#(
  parameter int NUM_MOVES = NUM_MOVES_DEF,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  output logic [7:0]       resp
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

  tour_state_e      state_r,   state_nxt_s;
  logic [IDX_W-1:0] mv_indx_r, mv_indx_nxt_s;
  logic [15:0]      cmd_r,     cmd_nxt_s;
  logic             cmd_rdy_r, cmd_rdy_nxt_s;
  logic [15:0]      vert_cmd_s;
  logic [15:0]      horz_cmd_s;

  knight_move_decode u_decode (
    .move     (move),
    .vert_cmd (vert_cmd_s),
    .horz_cmd (horz_cmd_s)
  );

  // Sequencer state, move index and registered tour command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      mv_indx_r <= '0;
      cmd_r     <= 16'h0000;
      cmd_rdy_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      mv_indx_r <= mv_indx_nxt_s;
      cmd_r     <= cmd_nxt_s;
      cmd_rdy_r <= cmd_rdy_nxt_s;
    end
  end

  // Next-state logic; a leg command is loaded one cycle after entering VERT/HORZ
  // so the move read for the current index has settled.
  always_comb begin
    state_nxt_s   = state_r;
    mv_indx_nxt_s = mv_indx_r;
    cmd_nxt_s     = cmd_r;
    cmd_rdy_nxt_s = cmd_rdy_r;
    case (state_r)
      IDLE: begin
        if (start_tour) begin
          state_nxt_s   = VERT;
          mv_indx_nxt_s = '0;
          cmd_rdy_nxt_s = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      VERT: begin
        if (!cmd_rdy_r) begin
          cmd_nxt_s     = vert_cmd_s;
          cmd_rdy_nxt_s = 1'b1;
        end else if (clr_cmd_rdy) begin
          cmd_rdy_nxt_s = 1'b0;
          state_nxt_s   = VWAIT;
        end else begin
          state_nxt_s = VERT;
        end
      end
      VWAIT: begin
        if (send_resp) begin
          state_nxt_s = HORZ;
        end else begin
          state_nxt_s = VWAIT;
        end
      end
      HORZ: begin
        if (!cmd_rdy_r) begin
          cmd_nxt_s     = horz_cmd_s;
          cmd_rdy_nxt_s = 1'b1;
        end else if (clr_cmd_rdy) begin
          cmd_rdy_nxt_s = 1'b0;
          state_nxt_s   = HWAIT;
        end else begin
          state_nxt_s = HORZ;
        end
      end
      HWAIT: begin
        if (send_resp && (mv_indx_r == LAST_IDX)) begin
          state_nxt_s   = IDLE;
          mv_indx_nxt_s = '0;
        end else if (send_resp) begin
          state_nxt_s   = VERT;
          mv_indx_nxt_s = mv_indx_r + IDX_W'(1);
        end else begin
          state_nxt_s = HWAIT;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        mv_indx_nxt_s = '0;
        cmd_rdy_nxt_s = 1'b0;
      end
    endcase
  end

  assign mv_indx = mv_indx_r;
  assign cmd     = (state_r == IDLE) ? cmd_UART     : cmd_r;
  assign cmd_rdy = (state_r == IDLE) ? cmd_rdy_UART : cmd_rdy_r;
  assign resp    = (state_r == IDLE) ? RESP_DONE    : RESP_BUSY;

endmodule

// File: tb/tb_tour_move_sequencer.sv
// Directed/randomised bench for tour_move_sequencer: plays the cmd_proc and
// TourLogic roles and checks every leg against a (dy,dx) table model.
module tb_tour_move_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_tour = 1'b0;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART = 16'h0000;
  logic        cmd_rdy_UART = 1'b0;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [7:0]  resp;

  int checks = 0;
  int errors = 0;
  int legs   = 0;

  int move_bit [24];
  logic [7:0] moves [24];
  int dy_tab [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
  int dx_tab [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};

  assign move = moves[mv_indx];

  always #10 clk = ~clk;

  tour_move_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_tour   (start_tour),
    .move         (move),
    .mv_indx      (mv_indx),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .resp         (resp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected leg command from the knight displacement of move bit b
  function automatic logic [15:0] exp_leg(input int b, input bit vert);
    int d;
    logic [3:0] op;
    logic [7:0] hdg;
    d   = vert ? dy_tab[b] : dx_tab[b];
    op  = vert ? 4'h4 : 4'h5;
    if (vert) hdg = (d > 0) ? 8'h00 : 8'h7F;
    else      hdg = (d > 0) ? 8'hBF : 8'h3F;
    return {op, hdg, 4'((d < 0) ? -d : d)};
  endfunction

  task automatic load_tour(input bit directed);
    for (int i = 0; i < 24; i++) begin
      move_bit[i] = int'($urandom_range(7, 0));
    end
    if (directed) begin
      move_bit[0] = 0;
      move_bit[1] = 6;
    end
    for (int i = 0; i < 24; i++) moves[i] = 8'(1 << move_bit[i]);
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (cmd_rdy !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(cmd_rdy), 32'(1'b1));
    if (cmd_rdy === 1'b1) legs++;
  endtask

  // mode: 0 normal, 1 clr+send_resp together on vertical, 2 UART/start noise
  // in VWAIT, 3 stop in HWAIT before the final send_resp
  task automatic serve_move(input int idx, input int mode);
    logic [15:0] v;
    logic [15:0] h;
    v = exp_leg(move_bit[idx], 1'b1);
    h = exp_leg(move_bit[idx], 1'b0);
    wait_rdy("vert_rdy");
    chk("vert_cmd", 32'(cmd), 32'(v));
    chk("vert_idx", 32'(mv_indx), 32'(idx));
    chk("vert_resp", 32'(resp), 32'h5A);
    tick(); tick();
    chk("vert_stable", 32'(cmd), 32'(v));
    clr_cmd_rdy = 1'b1;
    if (mode == 1) send_resp = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    chk("vert_rdy_drop", 32'(cmd_rdy), 32'(1'b0));
    for (int k = 0; k < 9; k++) begin
      tick();
      if (mode == 2 && k == 3) begin
        cmd_UART     = 16'hDEAD;
        cmd_rdy_UART = 1'b1;
        start_tour   = 1'b1;
        tick();
        chk("noise_cmd", 32'(cmd), 32'(v));
        chk("noise_rdy", 32'(cmd_rdy), 32'(1'b0));
        cmd_rdy_UART = 1'b0;
        start_tour   = 1'b0;
      end
    end
    if (mode == 1) chk("both_clr_only", 32'(cmd_rdy), 32'(1'b0));
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    wait_rdy("horz_rdy");
    chk("horz_cmd", 32'(cmd), 32'(h));
    chk("horz_idx", 32'(mv_indx), 32'(idx));
    tick(); tick();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    chk("horz_rdy_drop", 32'(cmd_rdy), 32'(1'b0));
    repeat (9) tick();
    if (mode != 3) begin
      send_resp = 1'b1;
      chk("hwait_resp", 32'(resp), 32'h5A);
      tick();
      send_resp = 1'b0;
    end
  endtask

  initial begin
    bit seen_rdy;
    load_tour(1'b1);
    tick(); tick();
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'(1'b0));
    chk("rst_mv_indx", 32'(mv_indx), 32'(0));
    chk("rst_resp", 32'(resp), 32'hA5);
    rst_n = 1'b1;
    tick();

    // UART pass-through and send_resp while idle
    cmd_UART = 16'h2000;
    cmd_rdy_UART = 1'b1;
    #1;
    chk("uart_cmd", 32'(cmd), 32'h2000);
    chk("uart_rdy", 32'(cmd_rdy), 32'(1'b1));
    chk("uart_resp", 32'(resp), 32'hA5);
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    cmd_rdy_UART = 1'b0;
    #1;
    chk("idle_send_resp", 32'(resp), 32'hA5);
    chk("uart_rdy_low", 32'(cmd_rdy), 32'(1'b0));

    // Full tour
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
    chk("first_latency0", 32'(cmd_rdy), 32'(1'b0));
    tick();
    chk("first_latency1", 32'(cmd_rdy), 32'(1'b1));
    for (int i = 0; i < 24; i++) begin
      serve_move(i, (i == 2) ? 1 : ((i == 4) ? 2 : 0));
    end
    cmd_UART = 16'h1234;
    #1;
    chk("tour_legs", 32'(legs), 32'(48));
    chk("tour_end_resp", 32'(resp), 32'hA5);
    chk("tour_end_idx", 32'(mv_indx), 32'(0));
    chk("tour_end_uart", 32'(cmd), 32'h1234);

    // Reset during HWAIT of move 7
    load_tour(1'b0);
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
    for (int i = 0; i < 7; i++) serve_move(i, 0);
    serve_move(7, 3);
    chk("pre_rst_resp", 32'(resp), 32'h5A);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rdy", 32'(cmd_rdy), 32'(1'b0));
    chk("midrst_idx", 32'(mv_indx), 32'(0));
    chk("midrst_resp", 32'(resp), 32'hA5);
    tick();
    rst_n = 1'b1;
    seen_rdy = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (cmd_rdy !== 1'b0) seen_rdy = 1'b1;
    end
    chk("post_rst_no_cmd", 32'(seen_rdy), 32'(1'b0));
    chk("post_rst_idx", 32'(mv_indx), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
